det3x3_seq: RTL and testbench
=============================

Name: det3x3_seq

Overview:
- Sequential 3x3 signed determinant engine using cofactor expansion along row 0.
- Uses one shared multiplier and one accumulator, so area stays low at the cost of latency.
- Sits directly upstream of the 32-bit result selection mux and drives one of its two 32-bit data inputs.
- Valid/ready handshake on both sides.

Parameters:
- DATA_W, default 8: signed element width. Legal range is 2..9, so that 3*DATA_W+3 <= 32 and the result can never overflow.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  matrix on mat_in is valid.
- in_ready  out  1  engine idle; can accept a matrix.
- mat_in  in  9*DATA_W  element m[r][c] at bits [(3r+c)*DATA_W +: DATA_W]; two's complement.
- out_valid  out  1  det_out holds a finished result.
- out_ready  in  1  downstream accepts det_out.
- det_out  out  32  signed determinant, sign-extended to 32 bits.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - When rst is asserted: state=IDLE, in_ready=1, out_valid=0, det_out=0, and all internal registers (matrix, minor, column counter) are cleared.
- Formula: det = m00*(m11*m22 - m12*m21) - m01*(m10*m22 - m12*m20) + m02*(m10*m21 - m11*m20).
- States: IDLE, MP, MQ, MC, DONE. A column counter col runs 0..2.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture mat_in into the matrix register, clear det_out/acc to 0, set col=0, go to MP.
- Minor column pairs (x,y) by col: col0 -> (1,2), col1 -> (0,2), col2 -> (0,1).
- MP: minor <= m[1][x]*m[2][y]; go to MQ.
- MQ: minor <= minor - m[1][y]*m[2][x]; go to MC.
- MC:
  - acc <= acc + s*m[0][col]*minor, where s=+1 for col 0 and 2, and s=-1 for col 1.
  - If col=2, go to DONE; otherwise col+1 and go to MP.
- DONE:
  - out_valid=1, det_out=acc.
  - On out_ready, go to IDLE.
  - det_out retains its value after the handshake until the next capture.
- Latency:
  - Accept edge at cycle 0; compute occupies cycles 1..9; out_valid is high from cycle 10.
  - With out_ready tied high, a new matrix can be accepted every 11 cycles.
- Handshake rules:
  - in_ready is low in every non-IDLE state, so in_valid there is ignored and mat_in is not sampled.
  - out_valid and det_out stay stable while out_ready is low (unbounded backpressure).
  - The outputs in_ready and out_valid are never high together.
- Arithmetic:
  - Minor width is 2*DATA_W+1 signed; term width is 3*DATA_W+1; acc is 32-bit signed.
  - Every operand is sign-extended before multiply/add.
  - No saturation is needed within the legal DATA_W range.
- Reset mid-operation aborts the computation immediately. There is no partial output and out_valid=0.

Optional Feature:
- Macro DET_ZERO_FLAG_EN.
- Defined: adds output port det_zero (1 bit), registered and updated with det_out on the MC->DONE transition. It is 1 when the determinant equals 0, reset value 0, and held stable under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package det_pkg holds:
  - the DATA_W default and RES_W=32;
  - the state enum {IDLE,MP,MQ,MC,DONE};
  - an element-index function idx(r,c)=3r+c.
- One natural sub-module, det_mul_acc: signed multiplier plus add/subtract stage. Inputs are two operands, an accumulate input and a subtract flag; output is the combinational result. The FSM selects operands and the destination register.

Test Plan:
- Identity matrix (diag 1, DATA_W=8) -> det_out=0x00000001, out_valid rises exactly 10 cycles after the accept edge.
- [[1,2,3],[4,5,6],[7,8,10]] -> det_out=0xFFFFFFFD (-3).
- Extremes [[-128,-128,0],[0,-128,-128],[-128,0,-128]] -> det_out=0xFFC00000 (-4194304). All elements -128 -> 0, and det_zero=1 when DET_ZERO_FLAG_EN is defined.
- Backpressure: out_ready low for 5 cycles after DONE -> out_valid and det_out held, in_ready=0, and a changing in_valid/mat_in is ignored. Release -> in_ready=1 next cycle.
- Back-to-back: out_ready tied high, in_valid held with two matrices -> accepts spaced 11 cycles apart, results in order.
- rst pulsed during MQ of col 1 -> outputs immediately 0/idle. The next matrix [[2,0,0],[0,3,0],[0,0,4]] gives 24, unaffected by the aborted run.

Source files
------------

// File: rtl/det3x3_seq_pkg.sv
// Shared types and constants for the sequential 3x3 determinant engine.
package det_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int RES_W      = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MP   = 3'd1,
        MQ   = 3'd2,
        MC   = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic int idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/det3x3_seq_if.sv
// Valid/ready bundle between a matrix producer, the engine and the result mux.
interface det3x3_seq_if
    import det_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [9*DATA_W-1:0]   mat_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [RES_W-1:0]      det_out;

    modport master (
        output in_valid, mat_in, out_ready,
        input  in_ready, out_valid, det_out
    );

    modport slave (
        input  in_valid, mat_in, out_ready,
        output in_ready, out_valid, det_out
    );

endinterface

// File: rtl/det3x3_seq_mul_acc.sv
// Shared signed multiplier followed by an add/subtract into a wide result.
module det_mul_acc #(
    parameter int A_W = 8,
    parameter int B_W = 17,
    parameter int R_W = 32
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    input  logic signed [R_W-1:0] acc_i,
    input  logic                  sub_i,
    output logic signed [R_W-1:0] res_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] a_x;
    logic signed [P_W-1:0] b_x;
    logic signed [P_W-1:0] prod;
    logic signed [R_W-1:0] prod_x;

    always_comb begin
        a_x    = {{B_W{a_i[A_W-1]}}, a_i};
        b_x    = {{A_W{b_i[B_W-1]}}, b_i};
        prod   = a_x * b_x;
        prod_x = {{(R_W-P_W){prod[P_W-1]}}, prod};
        res_o  = sub_i ? (acc_i - prod_x) : (acc_i + prod_x);
    end

endmodule

// File: rtl/det3x3_seq.sv
// Sequential 3x3 determinant by row-0 cofactor expansion, one shared MAC.
// DET_ZERO_FLAG_EN adds a registered det_zero output.
module det3x3_seq
    import det_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    det3x3_seq_if.slave  bus
`ifdef DET_ZERO_FLAG_EN
    ,
    output logic         det_zero
`endif
);

    localparam int MIN_W = 2 * DATA_W + 1;

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_MP   = MP;
    localparam logic [2:0] S_MQ   = MQ;
    localparam logic [2:0] S_MC   = MC;
    localparam logic [2:0] S_DONE = DONE;

    logic [2:0]               state_q, state_d;
    logic [1:0]               col_q, col_d;
    logic signed [MIN_W-1:0]  minor_q, minor_d;
    logic signed [RES_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] m_q [9];
    logic                     cap;

    logic [1:0]               x_sel, y_sel;
    logic [3:0]               i_a, i_b;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [MIN_W-1:0]  mul_b;
    logic signed [RES_W-1:0]  mul_acc;
    logic                     mul_sub;
    logic signed [RES_W-1:0]  mul_res;

    function automatic logic signed [MIN_W-1:0] sx(
        input logic signed [DATA_W-1:0] v
    );
        return {{(MIN_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Minor columns: col0 -> (1,2), col1 -> (0,2), col2 -> (0,1)
    always_comb begin
        x_sel   = (col_q == 2'd0) ? 2'd1 : 2'd0;
        y_sel   = (col_q == 2'd2) ? 2'd1 : 2'd2;
        i_a     = '0;
        i_b     = '0;
        mul_a   = '0;
        mul_b   = '0;
        mul_acc = '0;
        mul_sub = 1'b0;
        unique case (state_q)
            S_MP: begin
                i_a   = 4'(idx(1, int'(x_sel)));
                i_b   = 4'(idx(2, int'(y_sel)));
                mul_a = m_q[i_a];
                mul_b = sx(m_q[i_b]);
            end
            S_MQ: begin
                i_a     = 4'(idx(1, int'(y_sel)));
                i_b     = 4'(idx(2, int'(x_sel)));
                mul_a   = m_q[i_a];
                mul_b   = sx(m_q[i_b]);
                mul_acc = {{(RES_W-MIN_W){minor_q[MIN_W-1]}}, minor_q};
                mul_sub = 1'b1;
            end
            S_MC: begin
                i_a     = 4'(idx(0, int'(col_q)));
                mul_a   = m_q[i_a];
                mul_b   = minor_q;
                mul_acc = acc_q;
                mul_sub = (col_q == 2'd1);
            end
            default: ;
        endcase
    end

    det_mul_acc #(
        .A_W (DATA_W),
        .B_W (MIN_W),
        .R_W (RES_W)
    ) u_mac (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .acc_i (mul_acc),
        .sub_i (mul_sub),
        .res_o (mul_res)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        minor_d = minor_q;
        acc_d   = acc_q;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    cap     = 1'b1;
                    acc_d   = '0;
                    minor_d = '0;
                    col_d   = 2'd0;
                    state_d = S_MP;
                end
            end
            S_MP: begin
                minor_d = mul_res[MIN_W-1:0];
                state_d = S_MQ;
            end
            S_MQ: begin
                minor_d = mul_res[MIN_W-1:0];
                state_d = S_MC;
            end
            S_MC: begin
                acc_d = mul_res;
                if (col_q == 2'd2) begin
                    state_d = S_DONE;
                end else begin
                    col_d   = col_q + 2'd1;
                    state_d = S_MP;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            minor_q <= '0;
            acc_q   <= '0;
            for (int k = 0; k < 9; k++) m_q[k] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            minor_q <= minor_d;
            acc_q   <= acc_d;
            if (cap) begin
                for (int k = 0; k < 9; k++)
                    m_q[k] <= bus.mat_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.det_out   = acc_q;

`ifdef DET_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (state_q == S_MC && col_q == 2'd2) begin
            zero_q <= (mul_res == '0);
        end
    end

    assign det_zero = zero_q;
`endif

endmodule

// File: tb/tb_det3x3_seq.sv
// Randomised and directed bench for det3x3_seq against a formula model.
module tb_det3x3_seq;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    det3x3_seq_if #(.DATA_W(DW)) bus ();

`ifdef DET_ZERO_FLAG_EN
    logic det_zero;
`endif

    det3x3_seq #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DET_ZERO_FLAG_EN
        ,
        .det_zero (det_zero)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9*DW-1:0] pack(input int e[9]);
        logic [9*DW-1:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(e[k]);
        return p;
    endfunction

    function automatic int det_ref(input int e[9]);
        return e[0] * (e[4] * e[8] - e[5] * e[7])
             - e[1] * (e[3] * e[8] - e[5] * e[6])
             + e[2] * (e[3] * e[7] - e[4] * e[6]);
    endfunction

    // Presents one matrix and waits for its result; cyc is the cycle
    // (accept cycle = 0) in which out_valid is first seen, -1 on timeout.
    task automatic apply(input int e[9], output logic [31:0] got,
                         output int cyc);
        int w;
        w = 0;
        while (!bus.in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        bus.mat_in   = pack(e);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        if (!bus.out_valid) cyc = -1;
        got = bus.det_out;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.mat_in    = '0;
        #12;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.det_out !== 32'h0) begin
            $display("FAIL reset: in_ready=%b out_valid=%b det_out=%h, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.det_out);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int          e[9];
        logic [31:0] got;
        int          cyc;
        logic [31:0] want [4];
        int          mats [4][9];
        mats[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        mats[1] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        mats[2] = '{-128, -128, 0, 0, -128, -128, -128, 0, -128};
        mats[3] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        want[0] = 32'h0000_0001;
        want[1] = 32'hFFFF_FFFD;
        want[2] = 32'hFFC0_0000;
        want[3] = 32'h0000_0000;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            e = mats[t];
            apply(e, got, cyc);
            vectors++;
            if (got !== want[t]) begin
                $display("FAIL directed%0d: det_out=%h want %h", t, got, want[t]);
                miscompares++;
            end
            if (t == 0) begin
                vectors++;
                if (cyc != 10) begin
                    $display("FAIL latency: out_valid in cycle %0d want 10", cyc);
                    miscompares++;
                end
            end
`ifdef DET_ZERO_FLAG_EN
            vectors++;
            if (det_zero !== (want[t] == 32'h0)) begin
                $display("FAIL det_zero%0d: got %b want %b", t, det_zero,
                         want[t] == 32'h0);
                miscompares++;
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int          e[9];
        logic [31:0] got;
        int          cyc;
        int          r;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 9; k++) e[k] = int'($urandom_range(0, 255)) - 128;
            if (n % 5 == 4) for (int k = 0; k < 3; k++) e[6+k] = e[3+k];
            r = det_ref(e);
            apply(e, got, cyc);
            vectors++;
            if (got !== 32'(r) || cyc != 10) begin
                $display("FAIL random%0d: det_out=%h cyc=%0d want %h cyc 10",
                         n, got, cyc, 32'(r));
                miscompares++;
            end
`ifdef DET_ZERO_FLAG_EN
            vectors++;
            if (det_zero !== (r == 0)) begin
                $display("FAIL rand_zero%0d: got %b want %b", n, det_zero, r == 0);
                miscompares++;
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int          e[9];
        logic [31:0] got;
        int          cyc;
        logic [31:0] want;
        e    = '{3, -7, 2, 5, 0, -1, 4, 9, -6};
        want = 32'(det_ref(e));
        bus.out_ready = 1'b0;
        apply(e, got, cyc);
        vectors++;
        if (got !== want) begin
            $display("FAIL bp_result: det_out=%h want %h", got, want);
            miscompares++;
        end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'($urandom);
            bus.mat_in   = {8'($urandom), 32'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.det_out !== want
                || bus.in_ready !== 1'b0) begin
                $display("FAIL bp_hold%0d: ov=%b det=%h ir=%b want 1 %h 0",
                         c, bus.out_valid, bus.det_out, bus.in_ready, want);
                miscompares++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.det_out !== want) begin
            $display("FAIL bp_release: ir=%b ov=%b det=%h want 1 0 %h",
                     bus.in_ready, bus.out_valid, bus.det_out, want);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int          a[9];
        int          b[9];
        int          acc_cyc[$];
        logic [31:0] res[$];
        logic        pre;
        a = '{2, 1, 0, -3, 4, 5, 1, 1, -2};
        b = '{-9, 8, 7, 6, -5, 4, 3, 2, 11};
        bus.out_ready = 1'b1;
        bus.mat_in    = pack(a);
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 60 && res.size() < 2; c++) begin
            pre = bus.in_ready;
            @(posedge clk); #1;
            if (pre) begin
                acc_cyc.push_back(c);
                if (acc_cyc.size() == 1) bus.mat_in = pack(b);
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) res.push_back(bus.det_out);
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 11) begin
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2 gap 11",
                     acc_cyc.size(),
                     acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1);
            miscompares++;
        end
        vectors++;
        if (res.size() != 2 || res[0] !== 32'(det_ref(a))
            || res[1] !== 32'(det_ref(b))) begin
            $display("FAIL b2b_order: n=%0d r0=%h r1=%h want %h %h", res.size(),
                     res.size() > 0 ? res[0] : 32'hx,
                     res.size() > 1 ? res[1] : 32'hx,
                     32'(det_ref(a)), 32'(det_ref(b)));
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int          e[9];
        logic [31:0] got;
        int          cyc;
        e = '{7, 7, 7, 1, 2, 3, -4, 5, 6};
        bus.out_ready = 1'b1;
        bus.mat_in    = pack(e);
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.det_out !== 32'h0) begin
            $display("FAIL abort: ir=%b ov=%b det=%h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.det_out);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        e = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        apply(e, got, cyc);
        vectors++;
        if (got !== 32'd24 || cyc != 10) begin
            $display("FAIL after_abort: det_out=%h cyc=%0d want 00000018 cyc 10",
                     got, cyc);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
